// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: FSM state
// encoding, ALU operation encoding (also used by the ALU), opcode/funct
// constants, PC source select codes and the decoder result struct.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_FAULT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_XOR   = 3'b100,
        ALU_SLT   = 3'b101,
        ALU_SLTU  = 3'b110,
        ALU_PASSB = 3'b111
    } alu_op_e;

    // Instruction classes the FSM sequences differently.
    typedef enum logic [2:0] {
        CL_RALU, CL_IALU, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_JR
    } instr_class_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    typedef struct packed {
        instr_class_e cls;
        alu_op_e      alu_op;
        logic         alu_src_imm;  // ALU B = extended immediate
        logic         ext_zero;     // zero-extend immediate
        logic         legal;
    } dec_t;

endpackage

// File: rtl/mips_instr_decoder.sv
// Combinational instruction decoder.
//   instr : instruction register contents
//   dec   : {class, alu_op, alu_src_imm, ext_zero, legal}
// Unsupported opcodes or R-type funct codes return legal=0.
module mips_instr_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign unused_fields = ^instr[25:6];

    always_comb begin
        dec = '{CL_RALU, ALU_ADD, 1'b0, 1'b0, 1'b0};
        case (opcode)
            OP_RTYPE: begin
                dec.legal = 1'b1;
                case (funct)
                    FN_ADDU: dec.alu_op = ALU_ADD;
                    FN_SUBU: dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_XOR:  dec.alu_op = ALU_XOR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    FN_SLTU: dec.alu_op = ALU_SLTU;
                    FN_JR:   dec.cls    = CL_JR;
                    default: dec.legal  = 1'b0;
                endcase
            end
            OP_ADDIU: dec = '{CL_IALU, ALU_ADD,  1'b1, 1'b0, 1'b1};
            OP_SLTI:  dec = '{CL_IALU, ALU_SLT,  1'b1, 1'b0, 1'b1};
            OP_SLTIU: dec = '{CL_IALU, ALU_SLTU, 1'b1, 1'b0, 1'b1};
            OP_ANDI:  dec = '{CL_IALU, ALU_AND,  1'b1, 1'b1, 1'b1};
            OP_ORI:   dec = '{CL_IALU, ALU_OR,   1'b1, 1'b1, 1'b1};
            OP_XORI:  dec = '{CL_IALU, ALU_XOR,  1'b1, 1'b1, 1'b1};
            // Address = rs + sign-extended offset.
            OP_LW:    dec = '{CL_LW,   ALU_ADD,  1'b1, 1'b0, 1'b1};
            OP_SW:    dec = '{CL_SW,   ALU_ADD,  1'b1, 1'b0, 1'b1};
            // Branch compares rs - rt.
            OP_BEQ:   dec = '{CL_BEQ,  ALU_SUB,  1'b0, 1'b0, 1'b1};
            OP_BNE:   dec = '{CL_BNE,  ALU_SUB,  1'b0, 1'b0, 1'b1};
            OP_J:     dec = '{CL_J,    ALU_ADD,  1'b0, 1'b0, 1'b1};
            default:  dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB, terminal HALT and
// FAULT).
//   clk, rst_n        : clock, async active-low reset
//   instr             : IR contents, valid from DECODE onward
//   alu_zero          : ALU result is zero (EXEC)
//   mem_waitrequest   : memory stall for the current access
//   mux_ALU_ctrl, alu_op, ext_zero : ALU controls, driven in EXEC
//   pc_write, pc_src  : PC update strobe and source select
//   ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg : datapath
//   active, fault     : executing / sticky illegal-instruction flag
// Outputs are decoded from the registered state (plus instr and the stall
// and zero inputs) and forced to their idle values while rst_n is low, so
// reset takes effect on the outputs without waiting for a clock.
module mips_control_fsm
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        mem_waitrequest,
    output logic        mux_ALU_ctrl,
    output logic [2:0]  alu_op,
    output logic        ext_zero,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        active,
    output logic        fault
);

    state_e state_q, state_d;
    dec_t   dec;
    logic   rs_zero;

    mips_instr_decoder u_dec (
        .instr (instr),
        .dec   (dec)
    );

    assign rs_zero = (instr[25:21] == 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        mux_ALU_ctrl = 1'b0;
        alu_op       = ALU_ADD;
        ext_zero     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SEQ;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        active       = 1'b0;
        fault        = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    active   = 1'b1;
                    mem_read = 1'b1;
                    if (!mem_waitrequest) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = PC_SEQ;
                        state_d  = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    active  = 1'b1;
                    state_d = dec.legal ? ST_EXEC : ST_FAULT;
                end
                ST_EXEC: begin
                    active       = 1'b1;
                    alu_op       = dec.alu_op;
                    mux_ALU_ctrl = dec.alu_src_imm;
                    ext_zero     = dec.ext_zero;
                    case (dec.cls)
                        CL_RALU, CL_IALU: state_d = ST_WB;
                        CL_LW, CL_SW:     state_d = ST_MEM;
                        CL_BEQ, CL_BNE: begin
                            if ((dec.cls == CL_BEQ &&  alu_zero) ||
                                (dec.cls == CL_BNE && !alu_zero)) begin
                                pc_write = 1'b1;
                                pc_src   = PC_BRANCH;
                            end
                            state_d = ST_FETCH;
                        end
                        CL_J: begin
                            pc_write = 1'b1;
                            pc_src   = PC_JUMP;
                            state_d  = ST_FETCH;
                        end
                        CL_JR: begin
                            // jr $0 is the halt idiom: stop without touching PC.
                            if (rs_zero) begin
                                state_d = ST_HALT;
                            end else begin
                                pc_write = 1'b1;
                                pc_src   = PC_RS;
                                state_d  = ST_FETCH;
                            end
                        end
                        default: state_d = ST_FAULT;
                    endcase
                end
                ST_MEM: begin
                    active    = 1'b1;
                    mem_read  = (dec.cls == CL_LW);
                    mem_write = (dec.cls != CL_LW);
                    if (!mem_waitrequest)
                        state_d = (dec.cls == CL_LW) ? ST_WB : ST_FETCH;
                end
                ST_WB: begin
                    active     = 1'b1;
                    reg_write  = 1'b1;
                    reg_dst    = (dec.cls == CL_RALU);
                    mem_to_reg = (dec.cls == CL_LW);
                    state_d    = ST_FETCH;
                end
                ST_HALT:  state_d = ST_HALT;
                ST_FAULT: fault   = 1'b1;
                default:  state_d = ST_FETCH;
            endcase
        end
    end

endmodule

// File: doc/mips_control_fsm.md
MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

Interface
REQ-001 SHALL have ports clk input 1 (rising-edge clock), then rst_n input 1 (reset, asynchronous, active-low); one clock, no other reset.
REQ-002 SHALL have instr input 32: instruction register contents, valid from DECODE onward.
REQ-003 SHALL have alu_zero input 1: ALU result equals zero, valid in EXEC.
REQ-004 SHALL have mem_waitrequest input 1: memory stall for the current access.
REQ-005 SHALL have mux_ALU_ctrl output 1: ALU B select, 0 = rt register, 1 = extended immediate.
REQ-006 SHALL have alu_op output 3: ADD=000, SUB=001, AND=010, OR=011, XOR=100, SLT=101, SLTU=110, PASSB=111.
REQ-007 SHALL have ext_zero output 1: 1 = zero-extend immediate, 0 = sign-extend.
REQ-008 SHALL have pc_write 1, pc_src 2 (00 PC+4, 01 branch target, 10 jump target, 11 rs) outputs.
REQ-009 SHALL have outputs ir_write, mem_read, mem_write, reg_write, reg_dst (1 = rd, 0 = rt) and mem_to_reg, 1 bit each.
REQ-010 SHALL have active output 1 (executing) and fault output 1 (sticky illegal-instruction flag).

Function
REQ-011 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT, with Moore outputs from the registered state plus instr.
REQ-012 FETCH: mem_read=1; hold while mem_waitrequest=1; on the cycle it drops, ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
REQ-013 DECODE: all strobes 0; go to EXEC if instr is supported, else go to FAULT.
REQ-014 Supported R-type (opcode 0) funct: ADDU 0x21, SUBU 0x23, AND 0x24, OR 0x25, XOR 0x26, SLT 0x2A, SLTU 0x2B, JR 0x08.
REQ-015 Supported I/J opcodes: ADDIU 0x09, SLTI 0x0A, SLTIU 0x0B, ANDI 0x0C, ORI 0x0D, XORI 0x0E, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02.
REQ-016 EXEC: R-type drives mux_ALU_ctrl=0 with alu_op per funct; immediate ALU ops, LW and SW drive mux_ALU_ctrl=1 with ADD/SLT/SLTU/AND/OR/XOR; ext_zero=1 only for ANDI/ORI/XORI.
REQ-017 EXEC branch: alu_op=SUB, mux_ALU_ctrl=0; pc_write=1 with pc_src=01 iff (BEQ and alu_zero) or (BNE and !alu_zero); then go to FETCH.
REQ-018 EXEC J: pc_write=1, pc_src=10, then FETCH; JR with rs!=0: pc_write=1, pc_src=11, then FETCH; JR with rs=0: go to HALT with no PC write.
REQ-019 EXEC to MEM for LW/SW, to WB for ALU instructions.
REQ-020 MEM: LW drives mem_read=1, SW drives mem_write=1, held stable while mem_waitrequest=1; on release LW goes to WB, SW goes to FETCH.
REQ-021 WB: reg_write=1 for exactly one cycle; reg_dst=1 for R-type, else 0; mem_to_reg=1 for LW only; then go to FETCH.
REQ-022 No branch delay slot; the architectural effect of any instruction completes before the next FETCH.
REQ-023 Latency from FETCH accept to next FETCH, zero wait: R/I-ALU 4 cycles, LW 5, SW 4, branch/J/JR 3.
REQ-024 HALT and FAULT are terminal until reset; all strobes 0; active=0; fault=1 only in FAULT.
REQ-025 Strobes not listed for a state SHALL be 0; mux outputs are don't-care only where a strobe does not consume them.

Reset
REQ-026 While rst_n=0, state=FETCH, all strobes=0, active=0, fault=0, alu_op=000, mux_ALU_ctrl=0, pc_src=00, asynchronously, including mid-instruction.
REQ-027 The first FETCH mem_read SHALL assert in the first cycle after rst_n deasserts; active=1 from then until HALT/FAULT.

Structure
REQ-028 Package mips_ctrl_pkg SHALL hold the state enum, alu_op enum, and opcode/funct constants, shared with the ALU.
REQ-029 Combinational sub-module mips_instr_decoder SHALL map instr to {class, alu_op, mux_ALU_ctrl, ext_zero, legal}; the FSM instantiates it once.

Verification
REQ-030 ADDU rd=3 (instr 0x00221821), no waits -> ir_write@FETCH, reg_write=1, reg_dst=1, alu_op=000 in WB; next FETCH 4 cycles after the first.
REQ-031 LW 0x8C220004 with mem_waitrequest high 2 cycles in MEM -> mem_read held 3 cycles, then WB mem_to_reg=1; total 7 cycles.
REQ-032 BEQ with alu_zero=1 -> EXEC pc_write=1, pc_src=01; with alu_zero=0 -> pc_write=0; BNE gives the inverse.
REQ-033 JR $0 (0x00000008) -> HALT, active=0, no further mem_read; opcode 0x3F -> FAULT, fault=1.
REQ-034 rst_n pulsed low during MEM of SW -> mem_write drops the same cycle; FETCH mem_read asserts on the first clock after release.
